// File: rtl/compensation_weight_loader.sv
// Streams one column of compensation weights from memory into a CPE chain head,
// reading addresses high-to-low so the row-0 weight is shifted in last.
module compensation_weight_loader #(
    parameter int unsigned COLUMN_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base_addr,
    input  logic                  load_pause,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [3:0]            mem_rd_data,
    output logic [3:0]            Compensation_Weight,
    output logic                  Compensation_Weight_out_valid,
    output logic                  busy,
    output logic                  load_done
);

    localparam int unsigned CntW = $clog2(COLUMN_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LastOffset = ADDR_WIDTH'(COLUMN_DEPTH - 1);
    localparam logic [CntW-1:0]       LastCnt    = CntW'(COLUMN_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_v1_q;
    logic                  valid_q;
    logic [3:0]            weight_q;
    logic                  issue;

    assign issue = (state_q == StRead) && !load_pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    addr_d  = load_base_addr + LastOffset;
                    cnt_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (issue) begin
                    addr_d = addr_q - ADDR_WIDTH'(1);
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = StFlush;
                    end
                end
            end
            // Last read has returned once nothing is left in the first pipe stage.
            StFlush: begin
                if (!rd_v1_q) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_rd_en = issue;
        busy      = (state_q == StRead) || (state_q == StFlush);
        load_done = (state_q == StDone);
    end

    // Two-stage beat pipeline: memory latency, then the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q  <= 1'b0;
            valid_q  <= 1'b0;
            weight_q <= '0;
        end else begin
            rd_v1_q <= issue;
            valid_q <= rd_v1_q;
            if (rd_v1_q) begin
                weight_q <= mem_rd_data;
            end
        end
    end

    assign mem_addr                      = addr_q;
    assign Compensation_Weight           = weight_q;
    assign Compensation_Weight_out_valid = valid_q;

endmodule

// File: tb/tb_compensation_weight_loader.sv
// Table-driven bench for compensation_weight_loader (D=4): per-cycle strobe masks plus
// address/weight scoreboards and a 4-CPE chain model.
module tb_compensation_weight_loader;

    localparam int unsigned D    = 4;
    localparam int unsigned AW   = 6;
    localparam int          NCYC = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic [AW-1:0] load_base_addr;
    logic          load_pause;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_rd_data;
    logic [3:0]    Compensation_Weight;
    logic          Compensation_Weight_out_valid;
    logic          busy;
    logic          load_done;

    compensation_weight_loader #(
        .COLUMN_DEPTH(D),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .load_start                   (load_start),
        .load_base_addr               (load_base_addr),
        .load_pause                   (load_pause),
        .mem_rd_en                    (mem_rd_en),
        .mem_addr                     (mem_addr),
        .mem_rd_data                  (mem_rd_data),
        .Compensation_Weight          (Compensation_Weight),
        .Compensation_Weight_out_valid(Compensation_Weight_out_valid),
        .busy                         (busy),
        .load_done                    (load_done)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [64];
    logic [3:0] chain [D];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Chain head is CPE 0; each valid beat pushes older weights toward CPE D-1.
    always @(posedge clk) begin
        if (Compensation_Weight_out_valid) begin
            for (int i = D - 1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= Compensation_Weight;
        end
    end

    typedef struct {
        logic [31:0] start;
        logic [31:0] acc;
        logic [31:0] pause;
        logic [31:0] rst;
        logic [31:0] rd;
        logic [31:0] vld;
        logic [31:0] bsy;
        logic [31:0] dn;
        logic [5:0]  base;
    } vec_t;

    vec_t vecs [7];

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] addr_sb [$];
    logic [3:0]    wt_sb [$];
    logic [3:0]    last_w;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t          v;
        logic [3:0]    got4;
        logic [3:0]    exp4;
        logic [AW-1:0] a;
        logic [3:0]    w;
        v = vecs[idx];
        load_base_addr = v.base;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            load_start = v.start[c];
            load_pause = v.pause[c];
            if (v.rst[c]) begin
                rst_n = 1'b0;
                addr_sb.delete();
                wt_sb.delete();
                last_w = 4'd0;
            end else begin
                rst_n = 1'b1;
            end
            if (v.acc[c]) begin
                for (int i = 0; i < int'(D); i++) begin
                    a = AW'(int'(v.base) + int'(D) - 1 - i);
                    addr_sb.push_back(a);
                    wt_sb.push_back(mem[a]);
                end
            end
            #1;
            got4 = {mem_rd_en, Compensation_Weight_out_valid, busy, load_done};
            exp4 = {v.rd[c], v.vld[c], v.bsy[c], v.dn[c]};
            check($sformatf("v%0d_c%0d_rd_vld_busy_done", idx, c), 32'(got4), 32'(exp4));
            if (v.rst[c]) begin
                check($sformatf("v%0d_c%0d_reset_addr", idx, c), 32'(mem_addr), 32'd0);
                check($sformatf("v%0d_c%0d_reset_weight", idx, c), 32'(Compensation_Weight), 32'd0);
            end
            if (mem_rd_en) begin
                if (addr_sb.size() == 0) begin
                    check($sformatf("v%0d_c%0d_unexpected_read", idx, c), 32'(mem_addr), 32'hFFFF);
                end else begin
                    a = addr_sb.pop_front();
                    check($sformatf("v%0d_c%0d_addr", idx, c), 32'(mem_addr), 32'(a));
                end
            end
            if (Compensation_Weight_out_valid) begin
                if (wt_sb.size() == 0) begin
                    check($sformatf("v%0d_c%0d_unexpected_beat", idx, c),
                          32'(Compensation_Weight), 32'hFFFF);
                end else begin
                    w = wt_sb.pop_front();
                    check($sformatf("v%0d_c%0d_beat", idx, c), 32'(Compensation_Weight), 32'(w));
                    last_w = w;
                end
            end else begin
                check($sformatf("v%0d_c%0d_hold", idx, c), 32'(Compensation_Weight), 32'(last_w));
            end
        end
        check($sformatf("v%0d_addr_sb_drained", idx), 32'(addr_sb.size()), 32'd0);
        check($sformatf("v%0d_wt_sb_drained", idx), 32'(wt_sb.size()), 32'd0);
        load_start = 1'b0;
        load_pause = 1'b0;
    endtask

    task automatic check_chain(input string name, input logic [5:0] base);
        for (int i = 0; i < int'(D); i++) begin
            check($sformatf("%s_row%0d", name, i), 32'(chain[i]), 32'(mem[AW'(int'(base) + i)]));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'(i * 5 + 7);
        mem[8] = 4'd1; mem[9] = 4'd2; mem[10] = 4'd3; mem[11] = 4'd4;

        //          start         acc           pause         rst           rd            vld           busy          done          base
        vecs[0] = '{32'h1,        32'h1,        32'h0,        32'h0,        32'h1E,       32'h78,       32'h7E,       32'h80,       6'd8};
        vecs[1] = '{32'h1,        32'h1,        32'h0,        32'h0,        32'h1E,       32'h78,       32'h7E,       32'h80,       6'd62};
        vecs[2] = '{32'h1,        32'h1,        32'hC,        32'h0,        32'h72,       32'h1C8,      32'h1FE,      32'h200,      6'd8};
        vecs[3] = '{32'h1,        32'h1,        32'h61,       32'h0,        32'h1E,       32'h78,       32'h7E,       32'h80,       6'd20};
        vecs[4] = '{32'h1,        32'h1,        32'h6,        32'h0,        32'h78,       32'h1E0,      32'h1FE,      32'h200,      6'd33};
        vecs[5] = '{32'h185,      32'h101,      32'h0,        32'h0,        32'h1E1E,     32'h7878,     32'h7E7E,     32'h8080,     6'd8};
        vecs[6] = '{32'h41,       32'h41,       32'h0,        32'h10,       32'h78E,      32'h1E08,     32'h1F8E,     32'h2000,     6'd8};

        rst_n          = 1'b0;
        load_start     = 1'b0;
        load_pause     = 1'b0;
        load_base_addr = '0;
        last_w         = 4'd0;
        for (int i = 0; i < int'(D); i++) chain[i] = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_strobes", 32'({mem_rd_en, Compensation_Weight_out_valid, busy, load_done}), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        check("reset_weight", 32'(Compensation_Weight), 32'd0);

        // Vector 0 releases reset and starts in the same cycle.
        run_vec(0);
        check_chain("chain_base8", 6'd8);
        run_vec(1);
        check_chain("chain_base62", 6'd62);
        for (int k = 2; k < 7; k++) run_vec(k);
        check_chain("chain_after_reset_load", 6'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
